kamacore_pipeline_controller: RTL and testbench
===============================================

// Module: kamacore_pipeline_controller
// PURPOSE
//  Hazard and stall sequencer for the 5-stage kamacore pipeline. Sits beside the forwarding unit.
//  Drives hold and flush/bubble controls into the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Resolves load-use hazards, hazards on operands of branches resolved in ID, taken-branch flush,
//  and multi-cycle data-memory waits. Keeps saturating stall and flush performance counters.
// PARAMETERS
//  REG_ADDR_WIDTH  5     register index width (shared package constant)
//  CNT_WIDTH       32    width of each performance counter
//  MEM_TIMEOUT     64    max MEM_WAIT cycles before mem_timeout is raised
// PORTS
//  clk            in   1               clock; single clock domain
//  rst            in   1               reset, synchronous, active-high
//  id_rs1_a       in   REG_ADDR_WIDTH  rs1 index of the instruction in ID
//  id_rs2_a       in   REG_ADDR_WIDTH  rs2 index of the instruction in ID
//  id_uses_rs1    in   1               ID instruction reads rs1
//  id_uses_rs2    in   1               ID instruction reads rs2
//  id_is_branch   in   1               ID instruction is a branch or jalr (resolved in ID)
//  ex_rd_a        in   REG_ADDR_WIDTH  destination register in EX
//  ex_rd_we       in   1               EX instruction writes rd
//  ex_is_load     in   1               EX instruction is a load
//  mem_rd_a       in   REG_ADDR_WIDTH  destination register in MEM
//  mem_is_load    in   1               MEM instruction is a load
//  branch_valid   in   1               branching unit: branch taken
//  mem_req        in   1               MEM stage data-memory request this cycle
//  mem_ready      in   1               data memory completes the request this cycle
//  hold_pc        out  1               PC keeps its value
//  hold_if_id     out  1               IF/ID register keeps its value
//  hold_id_ex     out  1               ID/EX register keeps its value
//  hold_ex_mem    out  1               EX/MEM register keeps its value
//  flush_if_id    out  1               IF/ID loads a NOP
//  bubble_id_ex   out  1               ID/EX loads a NOP (rd_we=0, no mem access)
//  bubble_mem_wb  out  1               MEM/WB loads a NOP
//  mem_timeout    out  1               sticky error; cleared only by rst
//  stall_count    out  CNT_WIDTH       cycles with hold_pc=1, saturates at all-ones
//  flush_count    out  CNT_WIDTH       cycles with flush_if_id=1, saturates at all-ones
// BEHAVIOUR
//  - Reset: state=RUN, counters=0, mem_timeout=0. All control outputs are 0 while rst=1.
//  - Match(a) = a!=0 && a==src && uses_src. x0 never creates a hazard.
//  - Hazard detection and control outputs are combinational, so controls act in the same cycle.
//    Only state, wait counter, mem_timeout and perf counters are registered.
//  - FSM states: RUN, MEM_WAIT.
//    * RUN -> MEM_WAIT when mem_req && !mem_ready.
//    * MEM_WAIT -> RUN on the cycle mem_ready=1.
//  - Memory wait (highest priority): in MEM_WAIT, or in RUN with mem_req && !mem_ready:
//    * hold_pc, hold_if_id, hold_id_ex, hold_ex_mem = 1; bubble_mem_wb = 1.
//    * All lower-priority actions are suppressed.
//  - Load-use: ex_is_load && Match(ex_rd_a) -> hold_pc, hold_if_id, bubble_id_ex for exactly 1 cycle.
//    The next cycle the load is in MEM and the forwarding unit covers it.
//  - Branch operand hazard (id_is_branch=1): stall with hold_pc, hold_if_id, bubble_id_ex
//    while either holds:
//    * ex_rd_we && Match(ex_rd_a)      (2 cycles if EX is a load, else 1), or
//    * mem_is_load && Match(mem_rd_a)  (1 cycle).
//    Stall length follows naturally as the producer advances; no explicit counter is used.
//  - Taken-branch flush: branch_valid && no stall or hold active -> flush_if_id=1 for 1 cycle.
//    While any stall is active, branch_valid is ignored; the branch is re-evaluated on release.
//  - Simultaneous memory wait and hazard: memory wait wins. ID/EX is held, not bubbled.
//  - Timeout counter:
//    * Clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
//    * Reaching MEM_TIMEOUT sets mem_timeout. The FSM keeps waiting; no recovery is attempted.
//  - Counters increment by 1 per qualifying cycle and saturate; they do not wrap.
//  - rst mid-MEM_WAIT: next cycle state=RUN and all outputs are 0.
// STRUCTURE
//  - Shared package (kamacore_datatypes): REG_ADDR_WIDTH, typedef enum pipe_ctrl_state_e
//    {RUN, MEM_WAIT}, typedef struct pipe_ctrl_s (the hold/flush/bubble bundle).
//  - One sub-module: kamacore_hazard_detector, a purely combinational match/priority function.
//    The FSM, timeout counter and perf counters stay in the top module.
// TESTING
//  - Load-use: lw x5 in EX, add x6,x5,x1 in ID -> hold_pc=hold_if_id=bubble_id_ex=1 for 1 cycle,
//    then 0; stall_count=1.
//  - x0: lw x0 in EX, ID reads x0 -> no stall, all controls 0.
//  - Branch after load: lw x7 in EX, beq x7,x2 in ID -> 2 stall cycles, then branch_valid=1
//    gives flush_if_id=1 for 1 cycle; flush_count=1.
//  - Memory wait: mem_req=1 with mem_ready low for 3 cycles -> 3 cycles of holds and
//    bubble_mem_wb=1, state returns to RUN the cycle mem_ready=1, stall_count=3.
//  - Timeout and priority: mem_ready low 70 cycles with MEM_TIMEOUT=64 -> mem_timeout=1 from
//    cycle 64 and stays set. Concurrent load-use and branch_valid are masked (bubble_id_ex=0,
//    flush_if_id=0). Assert rst -> all outputs 0 and counters 0 the next cycle.

Source files
------------

// File: rtl/kamacore_datatypes.sv
// Shared types and constants for the kamacore pipeline control logic.
package kamacore_datatypes;

   localparam int unsigned REG_ADDR_WIDTH = 5;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } pipe_ctrl_state_e;

   typedef struct packed {
      logic hold_pc;
      logic hold_if_id;
      logic hold_id_ex;
      logic hold_ex_mem;
      logic flush_if_id;
      logic bubble_id_ex;
      logic bubble_mem_wb;
   } pipe_ctrl_s;

   // A producer hits a source operand only if it is a real register that the consumer reads.
   function automatic logic reg_match(input logic [REG_ADDR_WIDTH-1:0] prod_a,
                                      input logic [REG_ADDR_WIDTH-1:0] src_a,
                                      input logic                      uses_src);
      return (prod_a != '0) && (prod_a == src_a) && uses_src;
   endfunction

endpackage

// File: rtl/kamacore_hazard_detector.sv
// Combinational hazard match and priority resolution for the pipeline controller.
module kamacore_hazard_detector
   import kamacore_datatypes::*;
(
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1_a,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2_a,
   input  logic                      id_uses_rs1,
   input  logic                      id_uses_rs2,
   input  logic                      id_is_branch,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd_a,
   input  logic                      ex_rd_we,
   input  logic                      ex_is_load,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd_a,
   input  logic                      mem_is_load,
   input  logic                      branch_valid,
   input  logic                      mem_wait,
   output pipe_ctrl_s                ctrl_c
);

   logic ex_hit;
   logic mem_hit;
   logic load_use;
   logic branch_hz;

   assign ex_hit    = reg_match(ex_rd_a, id_rs1_a, id_uses_rs1)
                    | reg_match(ex_rd_a, id_rs2_a, id_uses_rs2);
   assign mem_hit   = reg_match(mem_rd_a, id_rs1_a, id_uses_rs1)
                    | reg_match(mem_rd_a, id_rs2_a, id_uses_rs2);
   assign load_use  = ex_is_load & ex_hit;
   assign branch_hz = id_is_branch & ((ex_rd_we & ex_hit) | (mem_is_load & mem_hit));

   // Memory wait freezes everything; hazards bubble ID/EX; a taken branch flushes only when free.
   always_comb begin
      ctrl_c = '0;
      if (mem_wait) begin
         ctrl_c.hold_pc       = 1'b1;
         ctrl_c.hold_if_id    = 1'b1;
         ctrl_c.hold_id_ex    = 1'b1;
         ctrl_c.hold_ex_mem   = 1'b1;
         ctrl_c.bubble_mem_wb = 1'b1;
      end else if (load_use || branch_hz) begin
         ctrl_c.hold_pc      = 1'b1;
         ctrl_c.hold_if_id   = 1'b1;
         ctrl_c.bubble_id_ex = 1'b1;
      end else if (branch_valid) begin
         ctrl_c.flush_if_id = 1'b1;
      end
   end

endmodule

// File: rtl/kamacore_pipeline_controller.sv
// Hazard/stall sequencer for the 5-stage kamacore pipeline with memory-wait FSM and perf counters.
module kamacore_pipeline_controller
   import kamacore_datatypes::*;
#(
   parameter int unsigned CNT_WIDTH   = 32,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1_a,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2_a,
   input  logic                      id_uses_rs1,
   input  logic                      id_uses_rs2,
   input  logic                      id_is_branch,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd_a,
   input  logic                      ex_rd_we,
   input  logic                      ex_is_load,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd_a,
   input  logic                      mem_is_load,
   input  logic                      branch_valid,
   input  logic                      mem_req,
   input  logic                      mem_ready,
   output logic                      hold_pc,
   output logic                      hold_if_id,
   output logic                      hold_id_ex,
   output logic                      hold_ex_mem,
   output logic                      flush_if_id,
   output logic                      bubble_id_ex,
   output logic                      bubble_mem_wb,
   output logic                      mem_timeout,
   output logic [CNT_WIDTH-1:0]      stall_count,
   output logic [CNT_WIDTH-1:0]      flush_count
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   pipe_ctrl_state_e  state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              mem_wait;
   pipe_ctrl_s        ctrl;
   pipe_ctrl_s        ctrl_out;

   // The request that starts a wait already stalls in its first (RUN) cycle.
   assign mem_wait = ~mem_ready & ((state == MEM_WAIT) | mem_req);

   kamacore_hazard_detector u_hazard_detector (
      .id_rs1_a     (id_rs1_a),
      .id_rs2_a     (id_rs2_a),
      .id_uses_rs1  (id_uses_rs1),
      .id_uses_rs2  (id_uses_rs2),
      .id_is_branch (id_is_branch),
      .ex_rd_a      (ex_rd_a),
      .ex_rd_we     (ex_rd_we),
      .ex_is_load   (ex_is_load),
      .mem_rd_a     (mem_rd_a),
      .mem_is_load  (mem_is_load),
      .branch_valid (branch_valid),
      .mem_wait     (mem_wait),
      .ctrl_c       (ctrl)
   );

   assign ctrl_out      = rst ? '0 : ctrl;
   assign hold_pc       = ctrl_out.hold_pc;
   assign hold_if_id    = ctrl_out.hold_if_id;
   assign hold_id_ex    = ctrl_out.hold_id_ex;
   assign hold_ex_mem   = ctrl_out.hold_ex_mem;
   assign flush_if_id   = ctrl_out.flush_if_id;
   assign bubble_id_ex  = ctrl_out.bubble_id_ex;
   assign bubble_mem_wb = ctrl_out.bubble_mem_wb;

   // Wait FSM, sticky timeout and saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         case (state)
            RUN: begin
               if (mem_req && !mem_ready) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= '0;
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  state <= RUN;
               end else begin
                  if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + WAIT_W'(1);
                  if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) mem_timeout <= 1'b1;
               end
            end
            default: state <= RUN;
         endcase
         if (hold_pc && (stall_count != '1)) stall_count <= stall_count + CNT_WIDTH'(1);
         if (flush_if_id && (flush_count != '1)) flush_count <= flush_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_kamacore_pipeline_controller.sv
// Randomized self-checking bench for kamacore_pipeline_controller against a behavioural model.
module tb_kamacore_pipeline_controller;
   import kamacore_datatypes::*;

   localparam int unsigned CW  = 8;
   localparam int unsigned TMO = 64;
   localparam int unsigned AW  = REG_ADDR_WIDTH;
   localparam int          CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] id_rs1_a, id_rs2_a, ex_rd_a, mem_rd_a;
   logic          id_uses_rs1, id_uses_rs2, id_is_branch;
   logic          ex_rd_we, ex_is_load, mem_is_load;
   logic          branch_valid, mem_req, mem_ready;
   logic          hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
   logic          flush_if_id, bubble_id_ex, bubble_mem_wb, mem_timeout;
   logic [CW-1:0] stall_count, flush_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit         m_pending;
   int         m_wait_cycles;
   bit         m_tmo;
   int         m_stalls;
   int         m_flushes;
   logic [6:0] exp_ctl;

   always #5 clk = ~clk;

   kamacore_pipeline_controller #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_a(id_rs1_a), .id_rs2_a(id_rs2_a),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_branch(id_is_branch),
      .ex_rd_a(ex_rd_a), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
      .mem_rd_a(mem_rd_a), .mem_is_load(mem_is_load),
      .branch_valid(branch_valid), .mem_req(mem_req), .mem_ready(mem_ready),
      .hold_pc(hold_pc), .hold_if_id(hold_if_id), .hold_id_ex(hold_id_ex),
      .hold_ex_mem(hold_ex_mem), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
      .bubble_mem_wb(bubble_mem_wb), .mem_timeout(mem_timeout),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit reads_reg(input logic [AW-1:0] a);
      return (a != 0) && ((a == id_rs1_a && id_uses_rs1) || (a == id_rs2_a && id_uses_rs2));
   endfunction

   // Expected {hold_pc,hold_if_id,hold_id_ex,hold_ex_mem,flush_if_id,bubble_id_ex,bubble_mem_wb}
   function automatic logic [6:0] expect_ctl();
      bit waiting, hazard;
      if (rst) return 7'b0;
      waiting = !mem_ready && (m_pending || mem_req);
      hazard  = (ex_is_load && reads_reg(ex_rd_a)) ||
                (id_is_branch && ((ex_rd_we && reads_reg(ex_rd_a)) ||
                                  (mem_is_load && reads_reg(mem_rd_a))));
      if (waiting)      return 7'b1111001;
      if (hazard)       return 7'b1100010;
      if (branch_valid) return 7'b0000100;
      return 7'b0;
   endfunction

   // One clock: check combinational controls, advance the model, check registered outputs.
   task automatic cycle(input string tag);
      #1;
      exp_ctl = expect_ctl();
      check({tag, "_ctl"}, 32'({hold_pc, hold_if_id, hold_id_ex, hold_ex_mem,
                               flush_if_id, bubble_id_ex, bubble_mem_wb}), 32'(exp_ctl));
      @(posedge clk);
      #1;
      if (rst) begin
         m_pending = 0; m_wait_cycles = 0; m_tmo = 0; m_stalls = 0; m_flushes = 0;
      end else begin
         if (m_pending) begin
            if (mem_ready) m_pending = 0;
            else begin
               m_wait_cycles++;
               if (m_wait_cycles >= TMO) m_tmo = 1;
            end
         end else if (mem_req && !mem_ready) begin
            m_pending = 1;
            m_wait_cycles = 0;
         end
         if (exp_ctl[6] && m_stalls < CNT_MAX) m_stalls++;
         if (exp_ctl[2] && m_flushes < CNT_MAX) m_flushes++;
      end
      check({tag, "_stall_count"}, 32'(stall_count), 32'(m_stalls));
      check({tag, "_flush_count"}, 32'(flush_count), 32'(m_flushes));
      check({tag, "_mem_timeout"}, 32'(mem_timeout), 32'(m_tmo));
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 0;
      id_rs1_a = '0; id_rs2_a = '0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_is_branch = 0;
      ex_rd_a = '0; ex_rd_we = 0; ex_is_load = 0; mem_rd_a = '0; mem_is_load = 0;
      branch_valid = 0; mem_req = 0; mem_ready = 1;
   endtask

   initial begin
      idle();
      rst = 1;
      m_pending = 0; m_wait_cycles = 0; m_tmo = 0; m_stalls = 0; m_flushes = 0;
      @(negedge clk);
      cycle("reset0");
      cycle("reset1");
      rst = 0;

      // Load-use: lw x5 in EX, add x6,x5,x1 in ID
      ex_is_load = 1; ex_rd_we = 1; ex_rd_a = 5'd5;
      id_rs1_a = 5'd5; id_uses_rs1 = 1; id_rs2_a = 5'd1; id_uses_rs2 = 1;
      #1 check("lu_hold_pc", 32'(hold_pc), 32'd1);
      cycle("lu_stall");
      ex_is_load = 0; ex_rd_we = 0; ex_rd_a = '0; mem_is_load = 1; mem_rd_a = 5'd5;
      cycle("lu_release");
      check("lu_stall_total", 32'(stall_count), 32'd1);

      // x0 never creates a hazard
      idle();
      ex_is_load = 1; ex_rd_we = 1; ex_rd_a = '0; id_rs1_a = '0; id_uses_rs1 = 1;
      id_is_branch = 1;
      cycle("x0");
      check("x0_stall_total", 32'(stall_count), 32'd1);

      // Branch after load: lw x7 in EX, beq x7,x2 in ID
      idle();
      ex_is_load = 1; ex_rd_we = 1; ex_rd_a = 5'd7;
      id_is_branch = 1; id_rs1_a = 5'd7; id_uses_rs1 = 1; id_rs2_a = 5'd2; id_uses_rs2 = 1;
      branch_valid = 1;
      cycle("br_ld_1");
      ex_is_load = 0; ex_rd_we = 0; ex_rd_a = '0; mem_is_load = 1; mem_rd_a = 5'd7;
      cycle("br_ld_2");
      mem_is_load = 0; mem_rd_a = '0;
      #1 check("br_flush", 32'(flush_if_id), 32'd1);
      cycle("br_ld_flush");
      idle();
      cycle("br_ld_done");
      check("br_flush_total", 32'(flush_count), 32'd1);
      check("br_stall_total", 32'(stall_count), 32'd3);

      // Memory wait of three cycles
      mem_req = 1; mem_ready = 0;
      repeat (3) cycle("mw_wait");
      mem_ready = 1;
      #1 check("mw_release_hold", 32'(hold_pc), 32'd0);
      cycle("mw_ready");
      idle();
      cycle("mw_idle");
      check("mw_stall_total", 32'(stall_count), 32'd6);

      // Long wait with masked load-use and taken branch, then reset mid-wait
      mem_req = 1; mem_ready = 0;
      ex_is_load = 1; ex_rd_we = 1; ex_rd_a = 5'd9; id_rs1_a = 5'd9; id_uses_rs1 = 1;
      branch_valid = 1;
      for (int i = 0; i < 70; i++) cycle("tmo_wait");
      check("tmo_sticky", 32'(mem_timeout), 32'd1);
      mem_req = 0;
      rst = 1;
      cycle("tmo_rst");
      check("tmo_rst_stall", 32'(stall_count), 32'd0);
      idle();
      cycle("tmo_after_rst");

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 799) == 0);
         id_rs1_a     = AW'($urandom_range(0, 7));
         id_rs2_a     = AW'($urandom_range(0, 7));
         id_uses_rs1  = $urandom_range(0, 3) != 0;
         id_uses_rs2  = $urandom_range(0, 1) != 0;
         id_is_branch = $urandom_range(0, 2) == 0;
         ex_rd_a      = AW'($urandom_range(0, 7));
         ex_rd_we     = $urandom_range(0, 3) != 0;
         ex_is_load   = $urandom_range(0, 3) == 0;
         mem_rd_a     = AW'($urandom_range(0, 7));
         mem_is_load  = $urandom_range(0, 3) == 0;
         branch_valid = $urandom_range(0, 2) == 0;
         mem_req      = $urandom_range(0, 7) == 0;
         mem_ready    = m_pending ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
